// File: rtl/pq_dispatcher_if.sv
// Pop-side bundle between the priority-queue dispatcher and its surroundings:
// enable/tick control, queue head view, pop request and the dispatched-cell stream.
interface pq_dispatcher_if #(
  parameter int TIME_WIDTH     = 24,
  parameter int PAYLOAD_WIDTH  = 8,
  parameter int LATE_CNT_WIDTH = 16
);
  logic                      enable_i;
  logic                      tick_i;
  logic [TIME_WIDTH-1:0]     time_o;
  logic                      head_valid_i;
  logic [TIME_WIDTH-1:0]     head_data_i;
  logic [TIME_WIDTH-1:0]     head_id_i;
  logic [PAYLOAD_WIDTH-1:0]  head_payload_i;
  logic                      pop_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [TIME_WIDTH-1:0]     out_data_o;
  logic [TIME_WIDTH-1:0]     out_id_o;
  logic [PAYLOAD_WIDTH-1:0]  out_payload_o;
  logic [TIME_WIDTH-1:0]     out_lateness_o;
  logic [LATE_CNT_WIDTH-1:0] late_cnt_o;

  modport slave (
    input  enable_i, tick_i, head_valid_i, head_data_i, head_id_i, head_payload_i, out_ready_i,
    output time_o, pop_o, out_valid_o, out_data_o, out_id_o, out_payload_o, out_lateness_o, late_cnt_o
  );

  modport master (
    output enable_i, tick_i, head_valid_i, head_data_i, head_id_i, head_payload_i, out_ready_i,
    input  time_o, pop_o, out_valid_o, out_data_o, out_id_o, out_payload_o, out_lateness_o, late_cnt_o
  );
endinterface

// File: rtl/pq_dispatcher.sv
// Pop-side dispatcher: keeps system time, pops the queue head once its deadline
// is reached and presents it with its lateness on a valid/ready stream.
module pq_dispatcher #(
  parameter int TIME_WIDTH     = 24,
  parameter int PAYLOAD_WIDTH  = 8,
  parameter int LATE_THRESH    = 20,
  parameter int LATE_CNT_WIDTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pq_dispatcher_if.slave dsp
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TIME_WIDTH-1:0]     r_time;
  logic [TIME_WIDTH-1:0]     w_diff;
  logic                      w_due;
  logic                      w_pop;
  logic                      w_late;
  logic                      r_out_valid;
  logic [TIME_WIDTH-1:0]     r_out_data;
  logic [TIME_WIDTH-1:0]     r_out_id;
  logic [PAYLOAD_WIDTH-1:0]  r_out_payload;
  logic [TIME_WIDTH-1:0]     r_out_lateness;
  logic [LATE_CNT_WIDTH-1:0] r_late_cnt;

  // Serial-number compare: the head is due when time minus deadline is non-negative mod 2^W.
  always_comb begin
    w_diff = r_time - dsp.head_data_i;
    w_due  = dsp.head_valid_i & ~w_diff[TIME_WIDTH-1];
    w_late = (w_diff > TIME_WIDTH'(LATE_THRESH));
  end

  // Next state and the Mealy pop request.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dsp.enable_i && w_due && !rst_i) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (r_out_valid && dsp.out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // System time counter, wrapping modulo 2^TIME_WIDTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_time <= {TIME_WIDTH{1'b0}};
    end else if (dsp.tick_i) begin
      r_time <= r_time + TIME_WIDTH'(1);
    end else begin
      r_time <= r_time;
    end
  end

  // Output cell capture on pop, release on handshake, saturating late counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= {TIME_WIDTH{1'b0}};
      r_out_id       <= {TIME_WIDTH{1'b0}};
      r_out_payload  <= {PAYLOAD_WIDTH{1'b0}};
      r_out_lateness <= {TIME_WIDTH{1'b0}};
      r_late_cnt     <= {LATE_CNT_WIDTH{1'b0}};
    end else if (w_pop) begin
      r_out_valid    <= 1'b1;
      r_out_data     <= dsp.head_data_i;
      r_out_id       <= dsp.head_id_i;
      r_out_payload  <= dsp.head_payload_i;
      r_out_lateness <= w_diff;
      if (w_late && (r_late_cnt != {LATE_CNT_WIDTH{1'b1}})) begin
        r_late_cnt <= r_late_cnt + LATE_CNT_WIDTH'(1);
      end else begin
        r_late_cnt <= r_late_cnt;
      end
    end else if (r_out_valid && dsp.out_ready_i) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign dsp.time_o         = r_time;
  assign dsp.pop_o          = w_pop;
  assign dsp.out_valid_o    = r_out_valid;
  assign dsp.out_data_o     = r_out_data;
  assign dsp.out_id_o       = r_out_id;
  assign dsp.out_payload_o  = r_out_payload;
  assign dsp.out_lateness_o = r_out_lateness;
  assign dsp.late_cnt_o     = r_late_cnt;

endmodule

// File: tb/tb_pq_dispatcher.sv
// Directed bench for pq_dispatcher; a narrow time width makes the wrap-around
// and a narrow late counter makes saturation reachable in a short run.
module tb_pq_dispatcher;
  localparam int TW = 10;
  localparam int PW = 8;
  localparam int LW = 3;
  localparam int TMOD = 1 << TW;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_fail;
  int   n_total;
  int   t_exp;
  logic found;

  pq_dispatcher_if #(.TIME_WIDTH(TW), .PAYLOAD_WIDTH(PW), .LATE_CNT_WIDTH(LW)) bus ();

  pq_dispatcher #(
    .TIME_WIDTH(TW), .PAYLOAD_WIDTH(PW), .LATE_THRESH(20), .LATE_CNT_WIDTH(LW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .dsp  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: also advances the bench's own model of the time counter.
  task automatic step();
    logic tk;
    logic rs;
    tk = bus.tick_i;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs) t_exp = 0;
    else if (tk) t_exp = (t_exp + 1) % TMOD;
  endtask

  task automatic tick_until(input int target);
    int guard;
    guard = 0;
    while (t_exp != target && guard < 5000) begin
      step();
      guard++;
    end
    chk("tick_until_time", 32'(bus.time_o), 32'(target));
  endtask

  task automatic wait_pop(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.pop_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic dispatch(input int d, input int id, input int pl, input int lat, input int cnt);
    bus.head_valid_i   = 1'b1;
    bus.head_data_i    = TW'(d);
    bus.head_id_i      = TW'(id);
    bus.head_payload_i = PW'(pl);
    bus.out_ready_i    = 1'b1;
    #1;
    chk("disp_pop", 32'(bus.pop_o), 32'd1);
    step();
    chk("disp_valid", 32'(bus.out_valid_o), 32'd1);
    chk("disp_data", 32'(bus.out_data_o), 32'(d));
    chk("disp_id", 32'(bus.out_id_o), 32'(id));
    chk("disp_payload", 32'(bus.out_payload_o), 32'(pl));
    chk("disp_lateness", 32'(bus.out_lateness_o), 32'(lat));
    chk("disp_late_cnt", 32'(bus.late_cnt_o), 32'(cnt));
    chk("disp_no_pop_in_out", 32'(bus.pop_o), 32'd0);
    bus.head_valid_i = 1'b0;
    step();
    chk("disp_done", 32'(bus.out_valid_o), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0; t_exp = 0;
    rst = 1'b1;
    bus.enable_i = 1'b1; bus.tick_i = 1'b1; bus.out_ready_i = 1'b1;
    bus.head_valid_i = 1'b1; bus.head_data_i = '0; bus.head_id_i = TW'(1); bus.head_payload_i = 8'h55;

    // Reset held two cycles with a due head.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_pop", 32'(bus.pop_o), 32'd0);
      chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_time", 32'(bus.time_o), 32'd0);
      chk("rst_late", 32'(bus.late_cnt_o), 32'd0);
      chk("rst_fields", 32'({bus.out_data_o, bus.out_id_o}), 32'd0);
      chk("rst_fields2", 32'({bus.out_payload_o, bus.out_lateness_o}), 32'd0);
    end
    rst = 1'b0; bus.tick_i = 1'b0; bus.head_valid_i = 1'b0;
    step();
    chk("rel_time", 32'(bus.time_o), 32'd0);

    // Basic dispatch at time 5.
    bus.tick_i = 1'b1; bus.head_valid_i = 1'b1; bus.head_data_i = TW'(5);
    bus.head_id_i = TW'(3); bus.head_payload_i = 8'hA5;
    #1;
    wait_pop(20, found);
    chk("basic_found", 32'(found), 32'd1);
    chk("basic_pop_time", 32'(bus.time_o), 32'd5);
    step();
    bus.tick_i = 1'b0;
    chk("basic_valid", 32'(bus.out_valid_o), 32'd1);
    chk("basic_data", 32'(bus.out_data_o), 32'd5);
    chk("basic_id", 32'(bus.out_id_o), 32'd3);
    chk("basic_payload", 32'(bus.out_payload_o), 32'hA5);
    chk("basic_lateness", 32'(bus.out_lateness_o), 32'd0);
    chk("basic_late_cnt", 32'(bus.late_cnt_o), 32'd0);
    bus.head_valid_i = 1'b0;
    step();
    chk("basic_done", 32'(bus.out_valid_o), 32'd0);

    // Backpressure: time is 6 here.
    bus.head_valid_i = 1'b1; bus.head_data_i = TW'(2); bus.head_id_i = TW'(7);
    bus.head_payload_i = 8'h3C; bus.out_ready_i = 1'b0;
    #1;
    chk("bp_pop", 32'(bus.pop_o), 32'd1);
    step();
    chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
    chk("bp_lateness", 32'(bus.out_lateness_o), 32'd4);
    bus.head_data_i = TW'(1); bus.head_id_i = TW'(9); bus.head_payload_i = 8'h11;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_pop", 32'(bus.pop_o), 32'd0);
      chk("bp_hold_valid", 32'(bus.out_valid_o), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data_o), 32'd2);
      chk("bp_hold_id", 32'(bus.out_id_o), 32'd7);
      chk("bp_hold_payload", 32'(bus.out_payload_o), 32'h3C);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_hs_no_pop", 32'(bus.pop_o), 32'd0);
    step();
    chk("bp_hs_valid", 32'(bus.out_valid_o), 32'd0);
    chk("bp_second_pop", 32'(bus.pop_o), 32'd1);
    step();
    chk("bp2_valid", 32'(bus.out_valid_o), 32'd1);
    chk("bp2_data", 32'(bus.out_data_o), 32'd1);
    chk("bp2_id", 32'(bus.out_id_o), 32'd9);
    chk("bp2_payload", 32'(bus.out_payload_o), 32'h11);
    chk("bp2_lateness", 32'(bus.out_lateness_o), 32'd5);
    bus.head_valid_i = 1'b0;
    step();
    chk("bp2_done", 32'(bus.out_valid_o), 32'd0);

    // Late counting, threshold edge and saturation.
    bus.tick_i = 1'b1;
    tick_until(100);
    bus.tick_i = 1'b0;
    dispatch(0, 1, 8'h01, 100, 1);
    dispatch(90, 2, 8'h02, 10, 1);
    dispatch(80, 3, 8'h03, 20, 1);
    dispatch(79, 4, 8'h04, 21, 2);
    for (int k = 3; k <= 7; k++) dispatch(0, k + 2, k, 100, k);
    dispatch(0, 10, 8'h0A, 100, 7);

    // Wrap: deadline 2 with time just below the wrap point.
    bus.tick_i = 1'b1;
    tick_until(TMOD - 3);
    bus.head_valid_i = 1'b1; bus.head_data_i = TW'(2); bus.head_id_i = TW'(11);
    bus.head_payload_i = 8'h77; bus.out_ready_i = 1'b1;
    #1;
    wait_pop(20, found);
    chk("wrap_found", 32'(found), 32'd1);
    chk("wrap_pop_time", 32'(bus.time_o), 32'd2);
    step();
    bus.tick_i = 1'b0;
    chk("wrap_valid", 32'(bus.out_valid_o), 32'd1);
    chk("wrap_data", 32'(bus.out_data_o), 32'd2);
    chk("wrap_lateness", 32'(bus.out_lateness_o), 32'd0);
    bus.head_valid_i = 1'b0;
    step();
    chk("wrap_done", 32'(bus.out_valid_o), 32'd0);
    dispatch(TMOD - 10, 12, 8'h0C, 13, 7);

    // Half-range ahead is never due.
    bus.tick_i = 1'b1;
    tick_until(0);
    bus.tick_i = 1'b0;
    bus.head_valid_i = 1'b1; bus.head_data_i = TW'(TMOD / 2);
    #1;
    chk("half_no_pop", 32'(bus.pop_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("half_no_pop_hold", 32'(bus.pop_o), 32'd0);
      chk("half_no_valid", 32'(bus.out_valid_o), 32'd0);
    end

    // Enable gating, then reset during a stalled output.
    bus.head_data_i = TW'(0); bus.enable_i = 1'b0;
    #1;
    chk("gate_no_pop", 32'(bus.pop_o), 32'd0);
    step();
    chk("gate_no_pop2", 32'(bus.pop_o), 32'd0);
    chk("gate_no_valid", 32'(bus.out_valid_o), 32'd0);
    bus.enable_i = 1'b1;
    #1;
    chk("gate_pop", 32'(bus.pop_o), 32'd1);
    bus.out_ready_i = 1'b0;
    step();
    chk("gate_valid", 32'(bus.out_valid_o), 32'd1);
    chk("gate_late_cnt", 32'(bus.late_cnt_o), 32'd7);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("mid_rst_late", 32'(bus.late_cnt_o), 32'd0);
    chk("mid_rst_time", 32'(bus.time_o), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data_o), 32'd0);
    chk("mid_rst_pop", 32'(bus.pop_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_pop", 32'(bus.pop_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
